mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter RR_FIRST, default 0, meaning the requester that wins the first two-way tie after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester N presents an operand pair.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  4  unsigned operands of requester N.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1  requester N's operands are accepted this cycle.
REQ-007 SHALL have ports rsp0_valid, rsp1_valid  output  1  product for requester N is available.
REQ-008 SHALL have ports rsp0_y, rsp1_y  output  8  unsigned product for requester N.
REQ-009 SHALL have ports rsp0_ready, rsp1_ready  input  1  requester N consumes its product.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL share exactly one combinational 4x4 unsigned multiplier between both requesters.
REQ-012 SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-013 In IDLE, reqN_ready SHALL be 1 only for the granted N; it is combinational from the reqN_valid inputs and FSM state, and 0 in EXEC and RESP.
REQ-014 Grant, one valid: SHALL go to that requester.
REQ-015 Grant, both valid: SHALL go to the requester not served last; before any service the winner is RR_FIRST.
REQ-016 On an accept edge (valid & ready), SHALL capture a, b and the owner id, update last-served to the owner, and move IDLE->EXEC.
REQ-017 In EXEC, the next edge SHALL register the multiplier output into an 8-bit result register and move EXEC->RESP.
REQ-018 In RESP, rspN_valid SHALL be 1 for the owner only; rspN_y SHALL show the result register.
REQ-019 Non-owner rsp_y SHALL be 0.
REQ-020 RESP SHALL hold while rsp_ready of the owner is 0.
REQ-021 On the edge where the owner's rsp_valid & rsp_ready, the FSM SHALL move RESP->IDLE.
REQ-022 Latency: rsp_valid SHALL rise exactly 2 edges after the accept edge; minimum issue interval is 3 cycles.
REQ-023 A non-owner rsp_ready SHALL be ignored.
REQ-024 reqN_valid deasserting in EXEC or RESP SHALL not affect the operation in flight.
REQ-025 Changes to req operands after acceptance SHALL not affect the result.
REQ-026 Product width SHALL be the full 8 bits with no truncation; 15*15 = 225 (0xE1).

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0: req*_ready, rsp*_valid, rsp*_y and busy.
REQ-028 While rst_n=0, the FSM SHALL be IDLE, the result and operand registers 0, and last-served set so that RR_FIRST wins the next tie.
REQ-029 Assertion of rst_n=0 mid-operation (EXEC or RESP) SHALL abort immediately and discard the pending result.
REQ-030 After rst_n rises, the first accept SHALL be possible on the first rising clk edge.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE/EXEC/RESP), the operand width (4) and the product width (8).
REQ-032 The single sub-module SHALL be the team's existing 4x4 array multiplier, four_bit_multiplier, instantiated once and fed from the captured operand registers.
REQ-033 The arbiter SHALL have no other hierarchy.

Verification
REQ-034 Single request: req0 a=3, b=5 held valid, rsp0_ready=1 -> req0_ready=1 in IDLE; rsp0_valid with rsp0_y=15 exactly 2 edges after accept; busy=0 the cycle after the handshake.
REQ-035 Tie/round robin: both valid continuously, RR_FIRST=0, operands (2,7) and (9,9) -> service order 0,1,0,1; products 14 and 81; each accept 3 cycles apart.
REQ-036 Backpressure: req1 a=15, b=15, rsp1_ready=0 for 5 cycles -> rsp1_valid with rsp1_y=225 held stable; no new accept until rsp1_ready=1.
REQ-037 Wrong-side ready: owner 0 in RESP, rsp1_ready=1 and rsp0_ready=0 -> FSM stays in RESP.
REQ-038 Operand change: a=4, b=4 accepted, then inputs changed to 0 in EXEC -> rsp0_y=16.
REQ-039 Mid-op reset: rst_n pulsed low in EXEC -> all outputs 0 immediately; after release with both valid, requester RR_FIRST is served first.
REQ-040 Exhaustive: all 256 operand pairs alternating between requesters -> every product equals a*b.

Source files
------------

// File: rtl/mul_arbiter_pkg.sv
// Shared types and widths for the two-requester multiply arbiter.
package mul_arbiter_pkg;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;
endpackage

// File: rtl/four_bit_multiplier.sv
// Combinational 4x4 unsigned array multiplier: shifted partial-product rows summed.
module four_bit_multiplier
  import mul_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] y_o
);
  logic [PROD_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < OP_W; i++) begin
      if (b_i[i]) acc = acc + (PROD_W'(a_i) << i);
    end
    y_o = acc;
  end
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier between two requesters.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned RR_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [PROD_W-1:0] rsp0_y,
  output logic [PROD_W-1:0] rsp1_y,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic              busy
);
  // last_q resets to the other requester so RR_FIRST wins the first tie
  localparam logic LAST_RST = (RR_FIRST == 0) ? 1'b1 : 1'b0;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0] res_q, res_d;
  logic [PROD_W-1:0] prod;
  logic              grant, accept, owner_rdy;

  four_bit_multiplier u_mult (
    .a_i(a_q),
    .b_i(b_q),
    .y_o(prod)
  );

  always_comb begin
    grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    // rst_n gating keeps ready low while reset holds the FSM in IDLE
    accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    owner_rdy  = owner_q ? rsp1_ready : rsp0_ready;
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) && owner_q;
    rsp0_y     = rsp0_valid ? res_q : '0;
    rsp1_y     = rsp1_valid ? res_q : '0;
    busy       = (state_q != IDLE);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          last_d  = grant;
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = prod;
        state_d = RESP;
      end
      RESP: begin
        if (owner_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= LAST_RST;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: directed vectors plus an all-pairs sweep.
module tb_mul_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_y, rsp1_y;
  logic       rsp0_ready, rsp1_ready;
  logic       busy;

  mul_arbiter #(.RR_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_y(rsp0_y), .rsp1_y(rsp1_y),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [7:0] y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [7:0] y);
    exp_t e;
    e.id = id;
    e.y  = y;
    sb.push_back(e);
  endtask

  // Monitor: handshakes pop the scoreboard; also tracks latency and issue spacing.
  int   cyc = 0, acc_cyc = 0, last_acc = 0;
  bit   acc_pend = 0, have_last = 0;
  logic prev_v0 = 0, prev_v1 = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      acc_pend  = 0;
      have_last = 0;
    end else begin
      if ((rsp0_valid && !prev_v0) || (rsp1_valid && !prev_v1)) begin
        chk("rsp_had_accept", 32'(acc_pend), 1);
        if (acc_pend) chk("latency", 32'(cyc - acc_cyc), 2);
        acc_pend = 0;
      end
      if (rsp0_valid && rsp0_ready) begin
        if (sb.size() == 0) chk("rsp0_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp0_owner", 32'(e.id), 0);
          chk("rsp0_y", 32'(rsp0_y), 32'(e.y));
          chk("rsp0_other_y", 32'(rsp1_y), 0);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (sb.size() == 0) chk("rsp1_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp1_owner", 32'(e.id), 1);
          chk("rsp1_y", 32'(rsp1_y), 32'(e.y));
          chk("rsp1_other_y", 32'(rsp0_y), 0);
        end
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        if (have_last) chk("issue_gap_ge3", 32'(cyc - last_acc >= 3), 1);
        last_acc  = cyc;
        have_last = 1;
        acc_pend  = 1;
        acc_cyc   = cyc;
      end
    end
    prev_v0 = rsp0_valid;
    prev_v1 = rsp1_valid;
  end

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, 32'(sb.size()), 0);
    chk({name, "_idle"}, 32'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    logic [7:0] y;
    y = {4'b0, a} * {4'b0, b};
    push(id, y);
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? req1_ready : req0_ready) && n < 20);
    chk("issue_ready", 32'(id ? req1_ready : req0_ready), 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset: outputs all 0 even with a valid request present
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst_rsp0_y", 32'(rsp0_y), 0);
    chk("rst_rsp1_y", 32'(rsp1_y), 0);
    chk("rst_busy", 32'(busy), 0);
    req0_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single request 3*5
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_a = 4'd3; req0_b = 4'd5; req0_valid = 1'b1;
    push(1'b0, 8'd15);
    @(negedge clk);
    chk("single_ready", 32'(req0_ready), 1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("single_busy_after_hs", 32'(busy), 0);
    drain("single");

    // Tie: order 0,1,0,1 with accepts 3 cycles apart
    reset_pulse();
    req0_a = 4'd2; req0_b = 4'd7; req1_a = 4'd9; req1_b = 4'd9;
    push(1'b0, 8'd14); push(1'b1, 8'd81); push(1'b0, 8'd14); push(1'b1, 8'd81);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rr_req0_ready", 32'(req0_ready), 32'(k % 6 == 0));
      chk("rr_req1_ready", 32'(req1_ready), 32'(k % 6 == 3));
      @(posedge clk);
    end
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    drain("rr");

    // Backpressure on requester 1 while requester 0 waits
    rsp1_ready = 1'b0;
    req1_a = 4'd15; req1_b = 4'd15; req1_valid = 1'b1;
    push(1'b1, 8'd225);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    req0_a = 4'd1; req0_b = 4'd1; req0_valid = 1'b1;
    push(1'b0, 8'd1);
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp1_valid", 32'(rsp1_valid), 1);
      chk("bp_rsp1_y", 32'(rsp1_y), 225);
      chk("bp_no_accept", 32'(req0_ready), 0);
    end
    @(posedge clk);
    #1 rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_req0_after", 32'(req0_ready), 1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    drain("bp");

    // Wrong-side ready must not release RESP
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_a = 4'd6; req0_b = 4'd7; req0_valid = 1'b1;
    push(1'b0, 8'd42);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("ws_rsp0_valid", 32'(rsp0_valid), 1);
      chk("ws_busy", 32'(busy), 1);
      chk("ws_rsp1_valid", 32'(rsp1_valid), 0);
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    drain("ws");

    // Operand change after acceptance
    req0_a = 4'd4; req0_b = 4'd4; req0_valid = 1'b1;
    push(1'b0, 8'd16);
    @(posedge clk);
    #1 req0_a = '0; req0_b = '0; req0_valid = 1'b0;
    drain("opchg");

    // Mid-operation reset, then tie goes to requester 0
    req0_a = 4'd5; req0_b = 4'd5; req0_valid = 1'b1;
    @(posedge clk);
    #1;
    req0_a = 4'd3; req0_b = 4'd4; req1_a = 4'd2; req1_b = 4'd2;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rsp0_valid", 32'(rsp0_valid), 0);
    chk("mid_rsp1_valid", 32'(rsp1_valid), 0);
    chk("mid_req0_ready", 32'(req0_ready), 0);
    chk("mid_req1_ready", 32'(req1_ready), 0);
    chk("mid_rsp0_y", 32'(rsp0_y), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    push(1'b0, 8'd12); push(1'b1, 8'd4);
    @(negedge clk);
    chk("mid_first_req0", 32'(req0_ready), 1);
    chk("mid_first_req1", 32'(req1_ready), 0);
    repeat (4) @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    drain("midrst");

    // All 256 operand pairs, alternating requesters
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      issue(v[0], v[7:4], v[3:0]);
    end
    drain("sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
